alu_rot_sequencer: RTL and testbench

Command-side initiator for the existing 8-bit add/sub/rotate datapath register, which exposes Input_1, Input_2, Control[2:0] and Output.
- Accepts one operation per valid/ready command: op, operands and rotate count.
- Drives the datapath Control/Input pins for the required number of cycles.
- Captures the datapath Output and returns it on a valid/ready response channel.
- Sits between the bus/test master and the datapath; both blocks share CLK and RST.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_rot_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_rot_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and datapath control encodings for the add/sub/rotate sequencer.
// No logic or latency of its own.
// Not applicable: types and constants only.
package alu_seq_pkg;

   // Command opcodes as presented on cmd_op
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ROTL = 2'b10,
      OP_ROTR = 2'b11
   } op_e;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      ROT     = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_e;

   // Datapath Control encodings: bit2 selects arithmetic, bit1 add/sub, bit0 rotate direction
   localparam logic [2:0] CTRL_ADD  = 3'b110;
   localparam logic [2:0] CTRL_SUB  = 3'b100;
   localparam logic [2:0] CTRL_ROTL = 3'b001;
   localparam logic [2:0] CTRL_ROTR = 3'b000;

endpackage

// File: rtl/alu_rot_sequencer.sv
// Command-side initiator: runs one add/sub/rotate on the external datapath register and returns the result.
// Latency accept->rsp_valid: 2 cycles for ADD/SUB and rotate count 0, N+2 cycles for rotate count N.
// cmd_ready only in IDLE (one command in flight); rsp_data held stable in RESP until rsp_ready.
module alu_rot_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [DATA_W-1:0] dp_input_1,
   output logic [DATA_W-1:0] dp_input_2,
   output logic [2:0]        dp_control,
   input  logic [DATA_W-1:0] dp_output
);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

   // State register; reset discards any command in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Next-state, command latch, rotate step counter and response capture
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d    = op_e'(cmd_op);
               a_d     = cmd_a;
               b_d     = cmd_b;
               cnt_d   = cmd_count;
               state_d = LOAD;
            end
         end
         LOAD: begin
            // Rotates with a zero count skip ROT: the loaded value is the result
            if ((op_q == OP_ROTL || op_q == OP_ROTR) && cnt_q != '0) begin
               state_d = ROT;
            end else begin
               state_d = CAPTURE;
            end
         end
         ROT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Datapath output already reflects the last operation at this edge
            rsp_data_d  = dp_output;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath drive decoded from state; it has no hold mode, so idle states load zero
   always_comb begin
      dp_control = CTRL_ADD;
      dp_input_1 = '0;
      dp_input_2 = '0;
      case (state_q)
         LOAD: begin
            case (op_q)
               OP_ADD: begin
                  dp_control = CTRL_ADD;
                  dp_input_1 = a_q;
                  dp_input_2 = b_q;
               end
               OP_SUB: begin
                  dp_control = CTRL_SUB;
                  dp_input_1 = a_q;
                  dp_input_2 = b_q;
               end
               default: begin
                  // Rotates start by loading a (a + 0)
                  dp_control = CTRL_ADD;
                  dp_input_1 = a_q;
                  dp_input_2 = '0;
               end
            endcase
         end
         ROT: begin
            dp_control = (op_q == OP_ROTL) ? CTRL_ROTL : CTRL_ROTR;
         end
         default: begin
            dp_control = CTRL_ADD;
         end
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_rot_sequencer.sv
// Bench for alu_rot_sequencer driving a behavioural copy of the 8-bit datapath register.
// Directed plan steps followed by randomized commands against an arithmetic reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_alu_rot_sequencer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] cmd_count;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [7:0] dp_input_1;
   logic [7:0] dp_input_2;
   logic [2:0] dp_control;
   logic [7:0] dp_output;

   int vectors     = 0;
   int miscompares = 0;

   alu_rot_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_count  (cmd_count),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .dp_input_1 (dp_input_1),
      .dp_input_2 (dp_input_2),
      .dp_control (dp_control),
      .dp_output  (dp_output)
   );

   always #5 CLK = ~CLK;

   // Stand-in for the existing datapath register sharing CLK and RST
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) dp_output <= 8'h00;
      else if (dp_control[2]) dp_output <= dp_control[1] ? dp_input_1 + dp_input_2 : dp_input_1 - dp_input_2;
      else if (dp_control[0]) dp_output <= {dp_output[6:0], dp_output[7]};
      else dp_output <= {dp_output[0], dp_output[7:1]};
   end

   // Expected result from the arithmetic meaning of each op
   function automatic int ref_result(input int op, input int a, input int b, input int n);
      int k;
      k = n % 8;
      case (op)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return ((a << k) | (a >> (8 - k))) & 255;
         default: return ((a >> k) | (a << (8 - k))) & 255;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One command end to end; hold>0 keeps rsp_ready low for that many cycles with a stray cmd_valid pulse
   task automatic run_cmd(input int op, input int a, input int b, input int n, input int hold);
      int         cycles;
      int         rotc;
      int         exp_lat;
      logic [7:0] held;
      logic [2:0] rot_ctrl;
      rot_ctrl = (op == 2) ? 3'b001 : 3'b000;
      exp_lat  = (op >= 2) ? n + 2 : 2;
      @(negedge CLK);
      check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op[1:0];
      cmd_a     = a[7:0];
      cmd_b     = b[7:0];
      cmd_count = n[3:0];
      rsp_ready = (hold == 0);
      @(negedge CLK);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_a     = 8'($urandom_range(0, 255));
      cmd_b     = 8'($urandom_range(0, 255));
      cmd_count = 4'($urandom_range(0, 15));
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      cycles = 0;
      rotc   = 0;
      while (!rsp_valid && cycles < 64) begin
         if (dp_control == rot_ctrl) rotc++;
         @(negedge CLK);
         cycles++;
      end
      check("latency", cycles, exp_lat);
      check("rsp_data", {24'd0, rsp_data}, ref_result(op, a, b, n));
      check("rot_steps", rotc, (op >= 2) ? n : 0);
      if (hold > 0) begin
         held = rsp_data;
         for (int i = 0; i < hold; i++) begin
            cmd_valid = (i == 0);
            @(negedge CLK);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_stable", {24'd0, rsp_data}, {24'd0, held});
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         end
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge CLK);
      check("rsp_done", {31'd0, rsp_valid}, 32'd0);
      check("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      RST       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_count = 4'h0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_dp_control", {29'd0, dp_control}, 32'd6);
      check("rst_dp_output", {24'd0, dp_output}, 32'd0);
      RST = 1'b0;

      // Directed plan steps
      run_cmd(0, 8'h80, 8'h01, 0, 0);
      run_cmd(1, 8'h18, 8'h04, 0, 0);
      run_cmd(1, 8'h00, 8'h01, 0, 0);
      run_cmd(2, 8'h81, 8'h00, 3, 0);
      run_cmd(3, 8'h01, 8'h00, 0, 0);
      run_cmd(3, 8'h01, 8'h00, 9, 0);
      run_cmd(2, 8'hA5, 8'h00, 8, 0);
      run_cmd(0, 8'h3C, 8'h0F, 0, 4);

      // Reset in the fourth rotate step of a count-10 ROTL
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_a     = 8'h5A;
      cmd_count = 4'd10;
      @(negedge CLK);
      cmd_valid = 1'b0;
      repeat (4) @(negedge CLK);
      check("pre_rst_rot_ctrl", {29'd0, dp_control}, 32'd1);
      RST = 1'b1;
      #1;
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("mid_rst_dp_output", {24'd0, dp_output}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      run_cmd(0, 8'h05, 8'h03, 0, 0);

      // Randomized commands
      repeat (30) begin
         run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
